usr_seq_ctrl: RTL and testbench

Command-driven sequencer for the 8-mode universal shift register. Accepts one operation at a time over a valid/ready command port. Drives the register's `mode`, `parallel_in` and `serial_in` for the required number of cycles, and returns the resulting register contents on a valid/ready response port. It sits between a host/CSR block and the shift register and also serves as the serial TX/RX front end.

---
 rtl/usr_seq_pkg.sv | 58 +++++
 rtl/usr_seq_bitcnt.sv | 40 ++++
 rtl/usr_seq_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_usr_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_seq_pkg.sv
// usr_seq_pkg -- shared definitions for the universal shift register sequencer.
//
// Contents:
//   op_e        command op codes carried on cmd_op
//   mode_e      shift register mode encoding (must match the register)
//   state_e     sequencer FSM states
//   shift_mode  op code -> register mode used while shifting
//
// Build option: USR_SEQ_PARITY_EN adds the ST_PAR state used by the
// serial parity cycle.
package usr_seq_pkg;

    typedef enum logic [2:0] {
        OP_LOAD = 3'b000,
        OP_TX   = 3'b001,
        OP_RX   = 3'b010,
        OP_SHL  = 3'b011,
        OP_SHR  = 3'b100,
        OP_ROL  = 3'b101,
        OP_ROR  = 3'b110,
        OP_ILL  = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        MODE_SISO = 3'b000,
        MODE_PIPO = 3'b001,
        MODE_SIPO = 3'b010,
        MODE_PISO = 3'b011,
        MODE_SHR  = 3'b100,
        MODE_SHL  = 3'b101,
        MODE_ROR  = 3'b110,
        MODE_ROL  = 3'b111
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
`ifdef USR_SEQ_PARITY_EN
        ST_PAR   = 3'd3,
`endif
        ST_RESP  = 3'd4
    } state_e;

    // TX and RX both shift right so the LSB leaves on serial_out and the
    // receive line enters at the MSB.
    function automatic mode_e shift_mode(input op_e op);
        mode_e m;
        case (op)
            OP_SHL:  m = MODE_SHL;
            OP_ROL:  m = MODE_ROL;
            OP_ROR:  m = MODE_ROR;
            default: m = MODE_SHR;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/usr_seq_bitcnt.sv
// usr_seq_bitcnt -- loadable shift-count down-counter.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         capture load_val (saturated to WIDTH)
//   load_val     requested shift count
//   dec          decrement by one (stops at zero)
//   last         count is exactly one: the current cycle is the final shift
//   zero         count is zero
module usr_seq_bitcnt #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last,
    output logic             zero
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (load_val > CNT_MAX) ? CNT_MAX : load_val;
        end else if (dec && !zero) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);
    assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/usr_seq_ctrl.sv
// usr_seq_ctrl -- command-driven sequencer for the 8-mode universal shift
// register; also acts as the serial TX/RX front end.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_op, cmd_data, cmd_cnt    op code, load/TX value, shift count
//   rsp_valid/rsp_ready          response handshake
//   rsp_data, rsp_err            register contents at completion, error flag
//   busy                         a command is in progress
//   ser_in                       serial receive line
//   ser_out, ser_oe              serial transmit data / output enable
//   usr_mode, usr_par, usr_sin   drive register mode, parallel_in, serial_in
//   usr_q, usr_sout              register q and serial_out
//
// Build option: USR_SEQ_PARITY_EN appends an even-parity cycle to TX and RX;
// an RX parity mismatch is reported on rsp_err.
module usr_seq_ctrl
    import usr_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             ser_oe,
    output logic [2:0]       usr_mode,
    output logic [WIDTH-1:0] usr_par,
    output logic             usr_sin,
    input  logic [WIDTH-1:0] usr_q,
    input  logic             usr_sout
);

    state_e           state, state_nxt;
    op_e              op_q;
    op_e              cmd_op_e;
    logic [WIDTH-1:0] data_q;
    logic             err_q;
    logic             accept;
    logic             cnt_load, cnt_dec, cnt_last, cnt_zero;
`ifdef USR_SEQ_PARITY_EN
    logic             par_q;
`endif

    assign cmd_op_e = op_e'(cmd_op);
    assign accept   = (state == ST_IDLE) && cmd_valid;

    usr_seq_bitcnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bitcnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cmd_cnt),
        .dec      (cnt_dec),
        .last     (cnt_last),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command capture and error/parity bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_LOAD;
            data_q <= '0;
            err_q  <= 1'b0;
`ifdef USR_SEQ_PARITY_EN
            par_q  <= 1'b0;
`endif
        end else begin
            if (accept) begin
                op_q   <= cmd_op_e;
                data_q <= cmd_data;
                err_q  <= (cmd_op_e == OP_ILL);
`ifdef USR_SEQ_PARITY_EN
                par_q  <= 1'b0;
`endif
            end
`ifdef USR_SEQ_PARITY_EN
            // Running XOR of the bits on the wire: TX bits leave via
            // serial_out, RX bits arrive via ser_in.
            if (state == ST_SHIFT) begin
                par_q <= par_q ^ ((op_q == OP_RX) ? ser_in : usr_sout);
            end
            if ((state == ST_PAR) && (op_q == OP_RX)) begin
                err_q <= ser_in ^ par_q;
            end
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        usr_mode  = MODE_PIPO;
        usr_par   = usr_q;
        usr_sin   = 1'b0;
        ser_out   = 1'b1;
        ser_oe    = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cnt_load = 1'b1;
                    case (cmd_op_e)
                        OP_LOAD, OP_TX: state_nxt = ST_LOAD;
                        OP_ILL:         state_nxt = ST_RESP;
                        default:        state_nxt = (cmd_cnt != '0) ? ST_SHIFT : ST_RESP;
                    endcase
                end
            end

            ST_LOAD: begin
                usr_par   = data_q;
                state_nxt = ((op_q == OP_TX) && !cnt_zero) ? ST_SHIFT : ST_RESP;
            end

            ST_SHIFT: begin
                usr_mode = shift_mode(op_q);
                cnt_dec  = 1'b1;
                if (op_q == OP_RX) begin
                    usr_sin = ser_in;
                end
                if (op_q == OP_TX) begin
                    ser_oe  = 1'b1;
                    ser_out = usr_sout;
                end
                if (cnt_last) begin
`ifdef USR_SEQ_PARITY_EN
                    state_nxt = ((op_q == OP_TX) || (op_q == OP_RX)) ? ST_PAR : ST_RESP;
`else
                    state_nxt = ST_RESP;
`endif
                end
            end

`ifdef USR_SEQ_PARITY_EN
            ST_PAR: begin
                if (op_q == OP_TX) begin
                    ser_oe  = 1'b1;
                    ser_out = par_q;
                end
                state_nxt = ST_RESP;
            end
`endif

            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy     = (state != ST_IDLE);
    assign rsp_data = usr_q;
    assign rsp_err  = err_q && (state == ST_RESP);

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Testbench for usr_seq_ctrl with a behavioural 8-mode shift register
// attached. Expected results come from an arithmetic reference model.
module tb_usr_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic [3:0] cmd_cnt;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err, busy;
    logic       ser_in, ser_out, ser_oe;
    logic [2:0] usr_mode;
    logic [7:0] usr_par;
    logic       usr_sin;
    logic [7:0] usr_q;
    logic       usr_sout;

    always #5 clk = ~clk;

    usr_seq_ctrl #(
        .WIDTH (8),
        .CNT_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_cnt   (cmd_cnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .ser_in    (ser_in),
        .ser_out   (ser_out),
        .ser_oe    (ser_oe),
        .usr_mode  (usr_mode),
        .usr_par   (usr_par),
        .usr_sin   (usr_sin),
        .usr_q     (usr_q),
        .usr_sout  (usr_sout)
    );

    // Universal shift register (no reset, no hold mode).
    logic [7:0] reg_q = 8'h00;
    always @(posedge clk) begin
        case (usr_mode)
            3'b001:  reg_q <= usr_par;
            3'b101:  reg_q <= {reg_q[6:0], usr_sin};
            3'b110:  reg_q <= {reg_q[0], reg_q[7:1]};
            3'b111:  reg_q <= {reg_q[6:0], reg_q[7]};
            default: reg_q <= {usr_sin, reg_q[7:1]};
        endcase
    end
    assign usr_q    = reg_q;
    assign usr_sout = reg_q[0];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [7:0]  exp_q = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: result, error flag, response latency and TX bit stream.
    task automatic ref_op(input int op, input int data, input int cnt, input int q0,
                          input int rxbits, input bit par_bad,
                          output int r_data, output bit r_err, output int r_lat,
                          output int r_txlen, output int r_txbits);
        int n, mask;
        n        = (cnt > 8) ? 8 : cnt;
        mask     = (1 << n) - 1;
        r_err    = 1'b0;
        r_txlen  = 0;
        r_txbits = 0;
        r_lat    = n;
        case (op)
            0: begin r_data = data; r_lat = 1; end
            1: begin
                r_data   = data >> n;
                r_lat    = 1 + n;
                r_txlen  = n;
                r_txbits = data & mask;
`ifdef USR_SEQ_PARITY_EN
                if (n > 0) begin
                    r_txbits = r_txbits | (($countones(data & mask) & 1) << n);
                    r_txlen++;
                    r_lat++;
                end
`endif
            end
            2: begin
                r_data = ((q0 >> n) | ((rxbits & mask) << (8 - n))) & 8'hFF;
`ifdef USR_SEQ_PARITY_EN
                if (n > 0) begin
                    r_lat++;
                    r_err = par_bad;
                end
`endif
            end
            3: r_data = (q0 << n) & 8'hFF;
            4: r_data = q0 >> n;
            5: r_data = ((q0 << n) | (q0 >> (8 - n))) & 8'hFF;
            6: r_data = ((q0 >> n) | (q0 << (8 - n))) & 8'hFF;
            default: begin r_data = q0; r_err = 1'b1; r_lat = 0; end
        endcase
    endtask

    task automatic wait_ready();
        int g;
        g = 0;
        while (!cmd_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
    endtask

    task automatic run_cmd(input int op, input int data, input int cnt, input int rxbits,
                           input bit par_bad, input int hold);
        int  e_data, e_lat, e_txlen, e_txbits, n, lat, obs_len, obs, idle_bad;
        bit  e_err;
        ref_op(op, data, cnt, exp_q, rxbits, par_bad, e_data, e_err, e_lat, e_txlen, e_txbits);
        n = (cnt > 8) ? 8 : cnt;
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_data  = 8'(data);
        cmd_cnt   = 4'(cnt);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_data  = 8'($urandom);
        cmd_cnt   = 4'($urandom);
        lat = 0; obs_len = 0; obs = 0; idle_bad = 0;
        while (!rsp_valid && lat < 40) begin
            if (op == 2) begin
                if (lat < n) ser_in = rxbits[lat];
                else         ser_in = 1'(($countones(rxbits & ((1 << n) - 1)) & 1) ^ int'(par_bad));
            end else begin
                ser_in = 1'($urandom);
            end
            if (ser_oe) begin
                if (obs_len < 16) obs = obs | (int'(ser_out) << obs_len);
                obs_len++;
            end else if (ser_out !== 1'b1) begin
                idle_bad++;
            end
            if (op == 0 && lat == 0) begin
                check("load_mode", usr_mode, 3'b001);
                check("load_par", usr_par, data);
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency", lat, e_lat);
        check("rsp_data", rsp_data, e_data);
        check("rsp_err", rsp_err, e_err);
        check("resp_mode", usr_mode, 3'b001);
        check("resp_busy", busy, 1);
        check("resp_oe", ser_oe, 0);
        check("tx_len", obs_len, e_txlen);
        check("tx_bits", obs, e_txbits);
        check("idle_ser_out", idle_bad, 0);
        for (int h = 0; h < hold; h++) begin
            if (h == 0) begin
                cmd_valid = 1'b1;
                cmd_op    = 3'b000;
                cmd_data  = 8'($urandom);
                cmd_cnt   = 4'd1;
            end
            @(posedge clk);
            @(negedge clk);
            cmd_valid = 1'b0;
            check("hold_valid", rsp_valid, 1);
            check("hold_data", rsp_data, e_data);
            check("hold_err", rsp_err, e_err);
            check("hold_mode", usr_mode, 3'b001);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_ready", cmd_ready, 1);
        check("post_valid", rsp_valid, 0);
        check("post_q", usr_q, e_data);
        exp_q = 8'(e_data);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_cnt = '0;
        rsp_ready = 1'b0; ser_in = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_busy", busy, 0);
        check("rst_ser_oe", ser_oe, 0);
        check("rst_ser_out", ser_out, 1);
        check("rst_mode", usr_mode, 3'b001);
        check("rst_par", usr_par, reg_q);
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd(0, 8'hA5, 0, 0, 1'b0, 1);
        run_cmd(1, 8'hC3, 8, 0, 1'b0, 0);
        run_cmd(2, 0, 8, 8'h4D, 1'b0, 2);
        run_cmd(0, 8'h81, 0, 0, 1'b0, 0);
        run_cmd(5, 0, 3, 0, 1'b0, 0);
        run_cmd(0, 8'h81, 0, 0, 1'b0, 0);
        run_cmd(5, 0, 12, 0, 1'b0, 0);
        run_cmd(3, 0, 0, 0, 1'b0, 0);
        run_cmd(7, 8'h5A, 4, 0, 1'b0, 5);
`ifdef USR_SEQ_PARITY_EN
        run_cmd(2, 0, 8, 8'h4D, 1'b1, 0);
`endif

        // Reset in the middle of a TX.
        wait_ready();
        cmd_valid = 1'b1; cmd_op = 3'b001; cmd_data = 8'hFF; cmd_cnt = 4'd8;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("mid_tx_oe", ser_oe, 1);
        rst_n = 1'b0;
        #1;
        check("rst_async_oe", ser_oe, 0);
        check("rst_async_out", ser_out, 1);
        check("rst_async_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_partial_q", usr_q, 8'h1F);
        check("rst_release_ready", cmd_ready, 1);
        exp_q = 8'h1F;
        run_cmd(0, 8'h3C, 0, 0, 1'b0, 0);

        for (int i = 0; i < 80; i++) begin
            run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                    1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
